timer_scheduler: RTL and testbench
==================================

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter CW, default 32, width of the period counter and PERIOD port.
REQ-002 SHALL have parameter RW, default 16, width of the repeat counter, REPEAT and TICK_COUNT.
REQ-003 SHALL have port CLOCK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port START  in  1  one-cycle request to begin a run.
REQ-006 SHALL have port STOP  in  1  one-cycle request to abort a run.
REQ-007 SHALL have port PAUSE  in  1  level; freezes the period counter while high.
REQ-008 SHALL have port PERIOD  in  CW  cycles per tick, sampled only when START is accepted.
REQ-009 SHALL have port REPEAT  in  RW  ticks per run, sampled only when START is accepted; 0 = continuous.
REQ-010 SHALL have port IRQ_ACK  in  1  clears IRQ.
REQ-011 SHALL have port TICK  out  1  one-cycle pulse per elapsed period.
REQ-012 SHALL have port BUSY  out  1  high in RUN or HOLD.
REQ-013 SHALL have port DONE  out  1  one-cycle pulse on normal run completion.
REQ-014 SHALL have port IRQ  out  1  sticky completion flag.
REQ-015 SHALL have port TICK_COUNT  out  RW  ticks issued in the current or last run.

Function
REQ-016 SHALL implement states IDLE, RUN, HOLD, FINISH; reset state IDLE.
REQ-017 SHALL accept START only in IDLE: latch PERIOD and REPEAT, clear period counter and TICK_COUNT, enter RUN.
REQ-018 SHALL ignore START in RUN, HOLD and FINISH.
REQ-019 SHALL treat latched PERIOD 0 as 1, i.e. TICK every RUN cycle.
REQ-020 SHALL, with START accepted at edge k and PAUSE low, assert the first TICK in cycle k+PERIOD and later ticks every PERIOD cycles.
REQ-021 SHALL assert TICK combinationally while period counter == PERIOD-1 in RUN, then clear the counter on the next edge.
REQ-022 SHALL increment TICK_COUNT on the edge ending each TICK cycle; wraps modulo 2^RW in continuous mode.
REQ-023 SHALL, when REPEAT != 0 and the TICK cycle is number REPEAT, transition RUN -> FINISH; no further TICK.
REQ-024 SHALL assert DONE for exactly the single FINISH cycle, then return to IDLE.
REQ-025 SHALL move RUN -> HOLD on an edge where PAUSE is high, freezing counter and TICK_COUNT, TICK low.
REQ-026 SHALL move HOLD -> RUN on an edge where PAUSE is low, resuming the count from the frozen value.
REQ-027 SHALL give PAUSE priority over a TICK due in the same cycle: the tick is deferred, not lost.
REQ-028 SHALL, on STOP in RUN or HOLD, return to IDLE next edge, keep TICK_COUNT, and assert no DONE or IRQ.
REQ-029 SHALL give STOP priority over PAUSE and over a same-cycle final TICK; that TICK still pulses and is counted.
REQ-030 SHALL set IRQ on the edge ending the DONE cycle; clear it on an edge with IRQ_ACK high; set wins over a simultaneous ack.
REQ-031 SHALL hold TICK_COUNT stable in IDLE until the next accepted START.

Reset
REQ-032 SHALL, on an edge with RESET high, force IDLE, clear counters and latched values, and drive TICK=0, BUSY=0, DONE=0, IRQ=0, TICK_COUNT=0.
REQ-033 SHALL let RESET override START, STOP, PAUSE and IRQ_ACK in the same cycle, including mid-run.

Structure
REQ-034 SHALL take state encodings (IDLE, RUN, HOLD, FINISH) and the default widths CW and RW from a shared timer package.
REQ-035 SHALL instantiate one sub-module, period_counter: enable, clear, period input, terminal-count pulse output.

Verification
REQ-036 SHALL test PERIOD=4, REPEAT=3, START at cycle 0 -> TICK at cycles 4, 8, 12; DONE at 13; IRQ high from 14; TICK_COUNT=3.
REQ-037 SHALL test PERIOD=0, REPEAT=2 -> TICK at cycles 1 and 2; DONE at 3.
REQ-038 SHALL test PERIOD=5, REPEAT=0, PAUSE high cycles 3-6 -> first TICK at cycle 9; BUSY stays high.
REQ-039 SHALL test PERIOD=4, REPEAT=0, STOP at cycle 6 -> BUSY low from 7; TICK_COUNT=1; no DONE or IRQ.
REQ-040 SHALL test IRQ_ACK coinciding with the IRQ-set edge -> IRQ stays high; a later ack clears it.
REQ-041 SHALL test RESET at cycle 5 of a PERIOD=8 run -> all outputs 0 next cycle; START at cycle 7 gives first TICK at cycle 15.

Source files
------------

// File: rtl/timer_scheduler_pkg.sv
// Shared definitions for the timer scheduler: state encoding and default counter widths.
package timer_scheduler_pkg;

    localparam int TIMER_CW = 32;
    localparam int TIMER_RW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/timer_scheduler_period_counter.sv
// Period counter: counts enabled cycles and flags the last cycle of each period.
// A programmed period of zero behaves as a period of one.
module period_counter
    import timer_scheduler_pkg::*;
#(
    parameter int CW = TIMER_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic [CW-1:0] period,
    output logic          tc
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_r;
    logic [CW-1:0] last_s;

    // Terminal count value for the current period
    always_comb begin
        if (period == {CW{1'b0}}) begin
            last_s = {CW{1'b0}};
        end else begin
            last_s = period - CNT_ONE;
        end
    end

    assign tc = (count_r == last_s);

    // Count register: wraps to zero on the enabled terminal cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            if (tc) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Periodic tick scheduler: issues REPEAT ticks spaced PERIOD cycles apart (or runs
// continuously), with pause/stop control, a done pulse and a sticky completion IRQ.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int CW = TIMER_CW,
    parameter int RW = TIMER_RW
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          START,
    input  logic          STOP,
    input  logic          PAUSE,
    input  logic [CW-1:0] PERIOD,
    input  logic [RW-1:0] REPEAT,
    input  logic          IRQ_ACK,
    output logic          TICK,
    output logic          BUSY,
    output logic          DONE,
    output logic          IRQ,
    output logic [RW-1:0] TICK_COUNT
);

    localparam logic [RW-1:0] RPT_ONE = {{(RW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] period_r;
    logic [RW-1:0] repeat_r;
    logic [RW-1:0] tick_count_r;
    logic          irq_r;

    logic          tc_s;
    logic          cnt_en_s;
    logic          cnt_clr_s;
    logic          start_acc_s;
    logic          tick_s;
    logic          busy_s;
    logic          done_s;
    logic          last_tick_s;

    period_counter #(
        .CW(CW)
    ) u_period_counter (
        .clock  (CLOCK),
        .reset  (RESET),
        .enable (cnt_en_s),
        .clear  (cnt_clr_s),
        .period (period_r),
        .tc     (tc_s)
    );

    assign last_tick_s = (repeat_r != {RW{1'b0}}) && (tick_count_r == (repeat_r - RPT_ONE));

    // Next state and per-cycle controls; STOP outranks PAUSE, PAUSE defers a due tick
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        tick_s      = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    start_acc_s = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s   = 1'b1;
                cnt_en_s = !PAUSE || STOP;
                tick_s   = tc_s && (!PAUSE || STOP);
                if (STOP) begin
                    state_nxt_s = ST_IDLE;
                end else if (PAUSE) begin
                    state_nxt_s = ST_HOLD;
                end else if (tick_s && last_tick_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                busy_s = 1'b1;
                // The resume cycle advances the count but never past the tick point
                cnt_en_s = !PAUSE && !tc_s;
                if (STOP) begin
                    state_nxt_s = ST_IDLE;
                end else if (!PAUSE) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_FINISH: begin
                done_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Run parameters latched at an accepted START; tick counter survives into IDLE
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            period_r     <= {CW{1'b0}};
            repeat_r     <= {RW{1'b0}};
            tick_count_r <= {RW{1'b0}};
        end else if (start_acc_s) begin
            period_r     <= PERIOD;
            repeat_r     <= REPEAT;
            tick_count_r <= {RW{1'b0}};
        end else if (tick_s) begin
            period_r     <= period_r;
            repeat_r     <= repeat_r;
            tick_count_r <= tick_count_r + RPT_ONE;
        end else begin
            period_r     <= period_r;
            repeat_r     <= repeat_r;
            tick_count_r <= tick_count_r;
        end
    end

    // Sticky completion flag; a set in the FINISH cycle beats a simultaneous ack
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            irq_r <= 1'b0;
        end else if (state_r == ST_FINISH) begin
            irq_r <= 1'b1;
        end else if (IRQ_ACK) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign TICK       = tick_s;
    assign BUSY       = busy_s;
    assign DONE       = done_s;
    assign IRQ        = irq_r;
    assign TICK_COUNT = tick_count_r;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed vector tables, hand-written corner
// sequences and a randomized run compared every cycle against a behavioural model.
module tb_timer_scheduler;

    localparam int CW = 16;
    localparam int RW = 4;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          START;
    logic          STOP;
    logic          PAUSE;
    logic [CW-1:0] PERIOD;
    logic [RW-1:0] REPEAT;
    logic          IRQ_ACK;
    logic          TICK;
    logic          BUSY;
    logic          DONE;
    logic          IRQ;
    logic [RW-1:0] TICK_COUNT;

    always #5 CLOCK = ~CLOCK;

    timer_scheduler #(
        .CW(CW),
        .RW(RW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .START      (START),
        .STOP       (STOP),
        .PAUSE      (PAUSE),
        .PERIOD     (PERIOD),
        .REPEAT     (REPEAT),
        .IRQ_ACK    (IRQ_ACK),
        .TICK       (TICK),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .IRQ        (IRQ),
        .TICK_COUNT (TICK_COUNT)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: run/hold/finishing flags, cycles elapsed in the current period,
    // total ticks issued (unbounded; the DUT shows it modulo 2^RW)
    bit m_valid = 1'b0;
    bit m_run, m_hold, m_fin, m_irq;
    int m_phase, m_per, m_rep, m_ticks;

    logic          s_tick, s_busy, s_done, s_irq;
    logic [RW-1:0] s_tc;

    typedef struct {
        bit start;
        int per;
        int rep;
        bit tick;
        bit busy;
        bit done;
        bit irq;
        int tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit start, int per, int rep, bit tick, bit busy,
                                bit done, bit irq, int tc);
        vec_t v;
        v.start = start; v.per = per; v.rep = rep;
        v.tick = tick; v.busy = busy; v.done = done; v.irq = irq; v.tc = tc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample and compare at the falling edge, advance model
    task automatic step(input bit rst, input bit st, input bit sp, input bit pa,
                        input bit ak, input int per, input int rep);
        bit e_tick;
        int e_tc;
        RESET = rst; START = st; STOP = sp; PAUSE = pa; IRQ_ACK = ak;
        PERIOD = CW'(per); REPEAT = RW'(rep);
        @(negedge CLOCK);
        s_tick = TICK; s_busy = BUSY; s_done = DONE; s_irq = IRQ; s_tc = TICK_COUNT;
        e_tick = m_run && (m_phase == m_per - 1) && (!pa || sp);
        e_tc   = m_ticks % (1 << RW);
        if (m_valid) begin
            chk("model_tick", TICK, e_tick);
            chk("model_busy", BUSY, m_run || m_hold);
            chk("model_done", DONE, m_fin);
            chk("model_irq", IRQ, m_irq);
            chk("model_tick_count", TICK_COUNT, e_tc);
        end
        if (rst) begin
            m_valid = 1'b1;
            m_run = 0; m_hold = 0; m_fin = 0; m_irq = 0;
            m_phase = 0; m_per = 1; m_rep = 0; m_ticks = 0;
        end else begin
            if (m_fin) m_irq = 1'b1;
            else if (ak) m_irq = 1'b0;
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (m_run) begin
                if (e_tick) m_ticks++;
                if (sp) begin
                    m_run = 1'b0;
                end else if (pa) begin
                    m_run = 1'b0; m_hold = 1'b1;
                end else if (e_tick) begin
                    m_phase = 0;
                    if (m_rep != 0 && m_ticks == m_rep) begin
                        m_run = 1'b0; m_fin = 1'b1;
                    end
                end else begin
                    m_phase++;
                end
            end else if (m_hold) begin
                if (sp) begin
                    m_hold = 1'b0;
                end else if (!pa) begin
                    m_hold = 1'b0; m_run = 1'b1;
                    if (m_phase < m_per - 1) m_phase++;
                end
            end else if (st) begin
                m_run = 1'b1; m_per = (per == 0) ? 1 : per; m_rep = rep;
                m_phase = 0; m_ticks = 0;
            end
        end
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            step(0, tbl[i].start, 0, 0, 0, tbl[i].per, tbl[i].rep);
            chk($sformatf("%s[%0d]_tick", tag, i), s_tick, tbl[i].tick);
            chk($sformatf("%s[%0d]_busy", tag, i), s_busy, tbl[i].busy);
            chk($sformatf("%s[%0d]_done", tag, i), s_done, tbl[i].done);
            chk($sformatf("%s[%0d]_irq", tag, i), s_irq, tbl[i].irq);
            chk($sformatf("%s[%0d]_tick_count", tag, i), s_tc, tbl[i].tc);
        end
        tbl.delete();
    endtask

    initial begin
        bit pause_lvl;
        RESET = 1'b1; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; IRQ_ACK = 1'b0;
        PERIOD = '0; REPEAT = '0;
        @(posedge CLOCK);
        #1;

        // Reset state
        do_reset();
        chk("reset_tick", s_tick, 0);
        chk("reset_busy", s_busy, 0);
        chk("reset_done", s_done, 0);
        chk("reset_irq", s_irq, 0);
        chk("reset_tick_count", s_tc, 0);

        // PERIOD=4, REPEAT=3: ticks at 4, 8, 12; DONE at 13; IRQ from 14
        tbl.push_back(mk(1, 4, 3, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 3; c++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        for (int c = 5; c <= 7; c++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1));
        for (int c = 9; c <= 11; c++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3));
        run_table("p4r3");

        // PERIOD=0 acts as 1, REPEAT=2: ticks at 1 and 2; DONE at 3
        do_reset();
        tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2));
        run_table("p0r2");

        // PAUSE cycles 3-6 with PERIOD=5 continuous: first tick at 9, next at 14
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            step(0, c == 0, 0, (c >= 3 && c <= 6), 0, 5, 0);
            if (c >= 1) begin
                chk($sformatf("pause_busy_c%0d", c), s_busy, 1);
                chk($sformatf("pause_tick_c%0d", c), s_tick, (c == 9 || c == 14));
            end
        end

        // STOP at cycle 6 of PERIOD=4 continuous run
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            step(0, c == 0, c == 6, 0, 0, 4, 0);
            if (c == 4) chk("stop_first_tick", s_tick, 1);
            if (c == 6) chk("stop_busy_c6", s_busy, 1);
            if (c >= 7) begin
                chk($sformatf("stop_busy_c%0d", c), s_busy, 0);
                chk($sformatf("stop_tick_count_c%0d", c), s_tc, 1);
            end
            chk($sformatf("stop_done_c%0d", c), s_done, 0);
            chk($sformatf("stop_irq_c%0d", c), s_irq, 0);
        end

        // IRQ_ACK on the IRQ-set edge loses; a later ack clears
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            step(0, c == 0, 0, 0, (c == 3 || c == 5), 2, 1);
            if (c == 2) chk("ack_tick_c2", s_tick, 1);
            if (c == 3) chk("ack_done_c3", s_done, 1);
            if (c == 4 || c == 5) chk($sformatf("ack_irq_held_c%0d", c), s_irq, 1);
            if (c >= 6) chk($sformatf("ack_irq_cleared_c%0d", c), s_irq, 0);
        end

        // RESET mid-run clears everything (including a pending IRQ); restart timing
        do_reset();
        step(0, 1, 0, 0, 0, 0, 2);
        for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_pre_irq", s_irq, 1);
        for (int c = 0; c <= 16; c++) begin
            step(c == 5, (c == 0 || c == 7), 0, 0, 0, 8, 0);
            if (c == 6) begin
                chk("rst_tick", s_tick, 0);
                chk("rst_busy", s_busy, 0);
                chk("rst_done", s_done, 0);
                chk("rst_irq", s_irq, 0);
                chk("rst_tick_count", s_tc, 0);
            end
            if (c >= 8) chk($sformatf("rst_run_busy_c%0d", c), s_busy, 1);
            if (c >= 8) chk($sformatf("rst_run_tick_c%0d", c), s_tick, (c == 15));
        end

        // Randomized traffic against the model
        do_reset();
        pause_lvl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) pause_lvl = !pause_lvl;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0, pause_lvl, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
